// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the execute-path control blocks.
//   XLEN        default datapath width
//   br_funct3_e branch condition codes (funct3 field of conditional branches)
//   br_state_e  branch_resolve FSM states
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational evaluation of a conditional-branch predicate.
//   funct3     in   branch condition code
//   rs1, rs2   in   operand values
//   cmp_lt     in   signed rs1 < rs2, supplied by the upstream comparator
//   cond_true  out  predicate holds (only meaningful when cond_legal)
//   cond_legal out  funct3 names a real branch condition
module branch_cond
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            cmp_lt,
  output logic            cond_true,
  output logic            cond_legal
);

  logic ult;

  // The comparator only supplies the signed result; unsigned is cheap enough to do here.
  assign ult = (rs1 < rs2);

  always_comb begin
    cond_true  = 1'b0;
    cond_legal = 1'b1;
    case (funct3)
      BEQ:     cond_true = (rs1 == rs2);
      BNE:     cond_true = (rs1 != rs2);
      BLT:     cond_true = cmp_lt;
      BGE:     cond_true = ~cmp_lt;
      BLTU:    cond_true = ult;
      BGEU:    cond_true = ~ult;
      default: cond_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: decides taken/not-taken for branches and jumps in execute,
// issues a registered fetch redirect with link value, then flushes the
// wrong-path instructions already fetched.
//   clk, rst            in   clock, synchronous active-high reset
//   ex_valid, ex_stall  in   execute-stage valid and pipeline hold
//   is_branch/jal/jalr  in   decoded transfer type (one-hot or zero)
//   funct3              in   branch condition code
//   pc, imm, rs1, rs2   in   instruction address, immediate, operands
//   cmp                 in   comparator result, bit 0 = signed rs1 < rs2
//   redir_valid         out  one-cycle redirect pulse
//   redir_pc, link_data out  redirect target and pc+4, held until next redirect
//   flush               out  kill wrong-path fetch/decode instructions
//   misalign            out  one-cycle pulse: taken target has bit 1 set
//   taken               out  one-cycle pulse for every taken transfer
//
// state | meaning
// IDLE  | evaluating execute-stage instructions
// FLUSH | redirect issued; flush asserted while fcnt counts down on unstalled cycles
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int XLEN         = cpu_pkg::XLEN,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] cmp,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  output logic [XLEN-1:0] link_data,
  output logic            flush,
  output logic            misalign,
  output logic            taken
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("branch_resolve: FLUSH_CYCLES must be at least 1");
  end

  br_state_e       state;
  logic [FW-1:0]   fcnt;

  logic            cond_true;
  logic            cond_legal;
  logic            accept;
  logic            take;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            unused_cmp;

  // Only the signed less-than flag in bit 0 carries information.
  assign unused_cmp = ^cmp[XLEN-1:1];

  branch_cond #(.XLEN(XLEN)) u_cond (
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .cmp_lt     (cmp[0]),
    .cond_true  (cond_true),
    .cond_legal (cond_legal)
  );

  assign accept   = (state == IDLE) & ex_valid & ~ex_stall & (is_branch | is_jal | is_jalr);
  assign take     = is_jal | is_jalr | (is_branch & cond_legal & cond_true);
  assign jalr_sum = rs1 + imm;
  assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);
  assign link     = pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fcnt        <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      link_data   <= '0;
      flush       <= 1'b0;
      misalign    <= 1'b0;
      taken       <= 1'b0;
    end else begin
      // Pulses clear every edge, stalled or not; only an acceptance re-raises them.
      redir_valid <= 1'b0;
      misalign    <= 1'b0;
      taken       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && take) begin
            taken <= 1'b1;
            if (target[1]) begin
              // Misaligned target: report it, but leave fetch on its current path.
              misalign <= 1'b1;
            end else begin
              redir_valid <= 1'b1;
              redir_pc    <= target;
              link_data   <= link;
              flush       <= 1'b1;
              fcnt        <= FW'(FLUSH_CYCLES);
              state       <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (!ex_stall) begin
            fcnt <= fcnt - 1'b1;
            if (fcnt == FW'(1)) begin
              flush <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Control-transfer resolution stage in the CPU execute path, directly downstream of `comparator`. It consumes the comparator's signed less-than result together with the raw operands, and decides whether BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL or JALR is taken. On a taken transfer it issues a registered fetch redirect and the link value. It then runs a small state machine that flushes the wrong-path instructions already in flight.

## Interface
- `XLEN`, 32: datapath width.
- `FLUSH_CYCLES`, 2: number of accepted pipeline cycles to flush after a redirect. Must be ≥ 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ex_valid`  in  1: execute-stage instruction valid.
- `ex_stall`  in  1: pipeline hold. While high, nothing is evaluated and no state advances.
- `is_branch`, `is_jal`, `is_jalr`  in  1 each: decoded type, one-hot or all zero.
- `funct3`  in  3: branch condition code.
- `pc`  in  XLEN: instruction address.
- `imm`  in  XLEN: sign-extended immediate.
- `rs1`, `rs2`  in  XLEN: operand values, identical to the comparator's `a`/`b`.
- `cmp`  in  XLEN: comparator output. Only bit 0 is used (signed rs1 < rs2).
- `redir_valid`  out  1: one-cycle redirect pulse.
- `redir_pc`  out  XLEN: redirect target.
- `link_data`  out  XLEN: pc+4, valid with `redir_valid` for JAL/JALR.
- `flush`  out  1: kill wrong-path instructions in the fetch/decode stages.
- `misalign`  out  1: one-cycle pulse when a taken target has bit 1 set.
- `taken`  out  1: one-cycle pulse for any taken transfer, including misaligned ones (performance counter).

## Operation
- States are IDLE and FLUSH. A down-counter `fcnt` is sized $clog2(FLUSH_CYCLES+1).
- **Accept condition (IDLE only):** `ex_valid & ~ex_stall & (is_branch|is_jal|is_jalr)`.
- **Branch conditions by funct3:**
  - 000: rs1==rs2
  - 001: rs1!=rs2
  - 100: cmp[0]
  - 101: ~cmp[0]
  - 110: unsigned rs1<rs2, computed internally
  - 111: ~(unsigned rs1<rs2)
  - 010/011: never taken, with no misalign and no pulse.
- **JAL/JALR** are always taken.
- **Targets:**
  - branch/JAL: pc+imm
  - JALR: (rs1+imm) & ~1
  - All sums are modulo 2^XLEN; wrap-around is silent.
- **Link value:** link = pc+4, wrapping at 2^XLEN.
- **Taken, target[1]==0:** next edge sets `redir_valid`=1, `redir_pc`, `link_data`, `taken`=1, then enters FLUSH with fcnt=FLUSH_CYCLES.
- **Taken, target[1]==1:** next edge sets `misalign`=1 and `taken`=1. No redirect, no flush, stays IDLE.
- **FLUSH state:**
  - `flush`=1.
  - fcnt decrements on each cycle with ~ex_stall.
  - Returns to IDLE on the edge where fcnt goes 1→0.
  - ex_valid and the instruction inputs are ignored (wrong path).
- **ex_stall in IDLE:** no evaluation. Pulse outputs drop to 0 next edge; the held instruction is evaluated once, when stall releases.
- **ex_stall in FLUSH:** fcnt frozen, `flush` stays 1.

## Timing
- **Reset values:**
  - `redir_valid`, `taken`, `misalign`, `flush` = 0
  - `redir_pc`, `link_data` = 0
  - state = IDLE, fcnt = 0
- **Reset mid-FLUSH:** back to IDLE next edge, all outputs 0. Reset overrides every other input in the same cycle.
- **Latency:** all outputs are registered, so an instruction accepted in cycle N produces its results on the edge ending cycle N.
- **Pulse width:**
  - `redir_valid`/`taken`/`misalign` are high exactly one cycle per accepted instruction.
  - `redir_pc`/`link_data` hold their values until the next redirect.
- **Flush timing:** `flush` rises in the same cycle as `redir_valid`. With no stall it stays high for exactly FLUSH_CYCLES cycles.
- **Back-to-back:** an instruction presented in the last FLUSH cycle is ignored. The first instruction presented after returning to IDLE is accepted.

## Structure
- **Shared `cpu_pkg`:**
  - `br_funct3_e`: BEQ=3'b000, BNE=3'b001, BLT=3'b100, BGE=3'b101, BLTU=3'b110, BGEU=3'b111
  - `br_state_e`: IDLE, FLUSH
  - `XLEN` default
- **Sub-module `branch_cond`:** combinational; inputs funct3, rs1, rs2, cmp[0]; outputs cond_true and cond_legal.
- **Top module contains:** target adders, link adder, FSM, fcnt and output registers.

## Test plan
- **BEQ taken:** pc=0x100, imm=0x20, rs1=rs2=5 → next cycle `redir_valid`=1, `redir_pc`=0x120, `flush` high for 2 cycles, then IDLE.
- **BLT vs BLTU on the same operands:** rs1=0xFFFFFFFF, rs2=1, cmp=1.
  - BLT: taken.
  - BLTU: not taken, no pulses.
- **JALR:**
  - rs1=0x203, imm=0 → target 0x202 has bit 1 set → `misalign`=1, `taken`=1, `redir_valid`=0, `flush`=0.
  - rs1=0x201, imm=0 → `redir_pc`=0x200, `link_data`=pc+4.
- **Stalls:**
  - ex_stall=1 for 3 cycles with a valid JAL → no outputs; on release, exactly one `redir_valid`.
  - ex_stall=1 during FLUSH → `flush` extends by the stall length.
- **Wrong-path and reset:**
  - A taken JAL immediately followed by a JAL presented during FLUSH → only one redirect.
  - rst=1 in the first FLUSH cycle → all outputs 0 next cycle.
- **Edge cases:**
  - funct3=010 with ex_valid, is_branch → no pulses.
  - pc=0xFFFFFFFC, JAL imm=8 → `redir_pc`=0x4, `link_data`=0x0.
